// File: rtl/step_tick_gen.sv
// step_tick_gen: step pulse (o_ena) and direction (o_inc) source for the 0-59 digit counters.
// Run mode emits a TICK_HZ tick; set mode steps from debounced buttons. Define AUTOREPEAT_EN for hold-to-repeat.
module step_tick_gen #(
    parameter int CLK_HZ        = 100_000_000,
    parameter int TICK_HZ       = 1,
    parameter int DEBOUNCE_CYC  = 1_000_000,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_run,
    input  logic i_btn_up,
    input  logic i_btn_dn,
    output logic o_ena,
    output logic o_inc
);

    localparam int PRESC_TERM = CLK_HZ / TICK_HZ - 1;
    localparam int PRESC_W    = (PRESC_TERM > 0) ? $clog2(PRESC_TERM + 1) : 1;
    localparam int DEB_W      = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC_TERM);
    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYC - 1);

    // A one-cycle prescaler or repeat interval would let o_ena stay high on consecutive cycles.
    if (PRESC_TERM < 1 || DEBOUNCE_CYC < 1 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_params
        $error("step_tick_gen: illegal parameter combination");
    end

`ifdef AUTOREPEAT_EN
    localparam int REP_SPAN = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W    = $clog2(REP_SPAN);
    localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD   = 2'd1,
        S_REPEAT = 2'd2,
        S_BLOCK  = 2'd3
    } state_e;

    // Bit 0 = up button, bit 1 = down button.
    logic [1:0]         sync1_q, sync2_q;
    logic [1:0]         deb_q, deb_d;
    logic [DEB_W-1:0]   deb_cnt_q [2];
    logic [DEB_W-1:0]   deb_cnt_d [2];

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               tick;

    state_e             state_q, state_d;
    logic               step_q, step_d;
    logic               dir_q, dir_d;
`ifdef AUTOREPEAT_EN
    logic [REP_W-1:0]   rep_cnt_q, rep_cnt_d;
`endif

    logic               o_ena_q, o_ena_d;
    logic               o_inc_q, o_inc_d;

    logic               btn_up, btn_dn, held;

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            deb_d[b]     = deb_q[b];
            deb_cnt_d[b] = '0;
            if (sync2_q[b] != deb_q[b]) begin
                if (deb_cnt_q[b] == DEB_LAST) begin
                    deb_d[b] = sync2_q[b];
                end else begin
                    deb_cnt_d[b] = deb_cnt_q[b] + DEB_W'(1);
                end
            end
        end
    end

    always_comb begin
        presc_d = '0;
        if (i_run && (presc_q != PRESC_LAST)) begin
            presc_d = presc_q + PRESC_W'(1);
        end
    end

    assign tick = i_run && (presc_q == PRESC_LAST);

    assign btn_up = deb_q[0];
    assign btn_dn = deb_q[1];
    // The button that started the current hold, selected by the direction it stepped in.
    assign held   = dir_q ? btn_up : btn_dn;

    always_comb begin
        state_d   = state_q;
        step_d    = 1'b0;
        dir_d     = dir_q;
`ifdef AUTOREPEAT_EN
        rep_cnt_d = '0;
`endif
        if (i_run) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (btn_up && btn_dn) begin
                        state_d = S_BLOCK;
                    end else if (btn_up) begin
                        step_d  = 1'b1;
                        dir_d   = 1'b1;
                        state_d = S_HOLD;
                    end else if (btn_dn) begin
                        step_d  = 1'b1;
                        dir_d   = 1'b0;
                        state_d = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (btn_up && btn_dn) begin
                        state_d = S_BLOCK;
                    end else if (!held) begin
                        state_d = S_IDLE;
`ifdef AUTOREPEAT_EN
                    end else if (rep_cnt_q == REP_DELAY_LAST) begin
                        step_d  = 1'b1;
                        state_d = S_REPEAT;
                    end else begin
                        rep_cnt_d = rep_cnt_q + REP_W'(1);
`endif
                    end
                end
`ifdef AUTOREPEAT_EN
                S_REPEAT: begin
                    if (btn_up && btn_dn) begin
                        state_d = S_BLOCK;
                    end else if (!held) begin
                        state_d = S_IDLE;
                    end else if (rep_cnt_q == REP_PERIOD_LAST) begin
                        step_d = 1'b1;
                    end else begin
                        rep_cnt_d = rep_cnt_q + REP_W'(1);
                    end
                end
`endif
                S_BLOCK: begin
                    if (!btn_up && !btn_dn) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // A step requested in set mode is dropped if run mode takes over before it reaches the output.
    always_comb begin
        o_ena_d = 1'b0;
        o_inc_d = o_inc_q;
        if (i_run) begin
            if (tick) begin
                o_ena_d = 1'b1;
                o_inc_d = 1'b1;
            end
        end else if (step_q) begin
            o_ena_d = 1'b1;
            o_inc_d = dir_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            // NOTE: the debounce counters are plain flops, not RAM, so they are cleared like any register.
            for (int b = 0; b < 2; b++) begin
                deb_cnt_q[b] <= '0;
            end
            presc_q   <= '0;
            state_q   <= S_IDLE;
            step_q    <= 1'b0;
            dir_q     <= 1'b1;
`ifdef AUTOREPEAT_EN
            rep_cnt_q <= '0;
`endif
            o_ena_q   <= 1'b0;
            o_inc_q   <= 1'b1;
        end else begin
            sync1_q   <= {i_btn_dn, i_btn_up};
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            for (int b = 0; b < 2; b++) begin
                deb_cnt_q[b] <= deb_cnt_d[b];
            end
            presc_q   <= presc_d;
            state_q   <= state_d;
            step_q    <= step_d;
            dir_q     <= dir_d;
`ifdef AUTOREPEAT_EN
            rep_cnt_q <= rep_cnt_d;
`endif
            o_ena_q   <= o_ena_d;
            o_inc_q   <= o_inc_d;
        end
    end

    assign o_ena = o_ena_q;
    assign o_inc = o_inc_q;

endmodule

// File: tb/tb_step_tick_gen.sv
// Directed bench for step_tick_gen with short timing parameters; expected pulse positions are hand-derived.
// Inputs change and outputs are sampled on the falling edge; sample k reflects the k-th rising edge after a change.
module tb_step_tick_gen;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic run    = 1'b0;
    logic btn_up = 1'b0;
    logic btn_dn = 1'b0;
    logic ena;
    logic inc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    step_tick_gen #(
        .CLK_HZ       (10),
        .TICK_HZ      (1),
        .DEBOUNCE_CYC (4),
        .REPEAT_DELAY (20),
        .REPEAT_PERIOD(5)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_run   (run),
        .i_btn_up(btn_up),
        .i_btn_dn(btn_dn),
        .o_ena   (ena),
        .o_inc   (inc)
    );

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; btn_up = 1'b0; btn_dn = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (ena !== 1'b0) begin
            bad++; $display("FAIL reset_ena: o_ena=%b expected 0", ena);
        end
        total++;
        if (inc !== 1'b1) begin
            bad++; $display("FAIL reset_inc: o_inc=%b expected 1", inc);
        end
        rst = 1'b0;
    endtask

    task automatic test_run_mode();
        logic exp_ena;
        rst = 1'b1; run = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k % 3 == 0) btn_up = ~btn_up;
            if (k % 7 == 0) btn_dn = ~btn_dn;
            @(negedge clk);
            exp_ena = (k % 10 == 0);
            total++;
            if (ena !== exp_ena) begin
                bad++; $display("FAIL run_tick k=%0d: o_ena=%b expected %b", k, ena, exp_ena);
            end
            total++;
            if (inc !== 1'b1) begin
                bad++; $display("FAIL run_inc k=%0d: o_inc=%b expected 1", k, inc);
            end
        end
        btn_up = 1'b0; btn_dn = 1'b0;
        repeat (10) @(negedge clk);
        run = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            total++;
            if (ena !== 1'b0) begin
                bad++; $display("FAIL run_to_set k=%0d: o_ena=%b expected 0", k, ena);
            end
        end
    endtask

    task automatic test_set_down();
        logic exp_ena;
        btn_dn = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (k == 10) btn_dn = 1'b0;
            exp_ena = (k == 8);
            total++;
            if (ena !== exp_ena) begin
                bad++; $display("FAIL set_down k=%0d: o_ena=%b expected %b", k, ena, exp_ena);
            end
            if (exp_ena) begin
                total++;
                if (inc !== 1'b0) begin
                    bad++; $display("FAIL set_down_inc k=%0d: o_inc=%b expected 0", k, inc);
                end
            end
        end
        total++;
        if (inc !== 1'b0) begin
            bad++; $display("FAIL set_down_inc_hold: o_inc=%b expected 0", inc);
        end
    endtask

    task automatic test_glitch();
        btn_up = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 3) btn_up = 1'b0;
            total++;
            if (ena !== 1'b0) begin
                bad++; $display("FAIL glitch k=%0d: o_ena=%b expected 0", k, ena);
            end
        end
        total++;
        if (inc !== 1'b0) begin
            bad++; $display("FAIL glitch_inc: o_inc=%b expected 0", inc);
        end
    endtask

    task automatic test_autorepeat();
        logic exp_ena;
        btn_up = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
`ifdef AUTOREPEAT_EN
            exp_ena = (k == 8) || (k >= 28 && k <= 48 && (k - 28) % 5 == 0);
`else
            exp_ena = (k == 8);
`endif
            total++;
            if (ena !== exp_ena) begin
                bad++; $display("FAIL autorepeat k=%0d: o_ena=%b expected %b", k, ena, exp_ena);
            end
            if (exp_ena) begin
                total++;
                if (inc !== 1'b1) begin
                    bad++; $display("FAIL autorepeat_inc k=%0d: o_inc=%b expected 1", k, inc);
                end
            end
        end
        btn_up = 1'b0;
        repeat (20) @(negedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            total++;
            if (ena !== 1'b0) begin
                bad++; $display("FAIL autorepeat_release k=%0d: o_ena=%b expected 0", k, ena);
            end
        end
    endtask

    task automatic test_both_block();
        logic exp_ena;
        btn_up = 1'b1; btn_dn = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 30) btn_up = 1'b0;
            if (k == 50) btn_dn = 1'b0;
            total++;
            if (ena !== 1'b0) begin
                bad++; $display("FAIL block k=%0d: o_ena=%b expected 0", k, ena);
            end
        end
        btn_up = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            exp_ena = (k == 8);
            total++;
            if (ena !== exp_ena) begin
                bad++; $display("FAIL block_exit k=%0d: o_ena=%b expected %b", k, ena, exp_ena);
            end
            if (exp_ena) begin
                total++;
                if (inc !== 1'b1) begin
                    bad++; $display("FAIL block_exit_inc k=%0d: o_inc=%b expected 1", k, inc);
                end
            end
        end
        btn_up = 1'b0;
        repeat (15) @(negedge clk);
    endtask

    task automatic test_reset_mid_hold();
        logic exp_ena;
        btn_dn = 1'b1;
        repeat (32) @(negedge clk);
        rst = 1'b1; btn_dn = 1'b0;
        @(negedge clk);
        total++;
        if (ena !== 1'b0) begin
            bad++; $display("FAIL reset_mid_ena: o_ena=%b expected 0", ena);
        end
        total++;
        if (inc !== 1'b1) begin
            bad++; $display("FAIL reset_mid_inc: o_inc=%b expected 1", inc);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            total++;
            if (ena !== 1'b0) begin
                bad++; $display("FAIL reset_mid_quiet k=%0d: o_ena=%b expected 0", k, ena);
            end
        end
        btn_dn = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            exp_ena = (k == 8);
            total++;
            if (ena !== exp_ena) begin
                bad++; $display("FAIL reset_mid_press k=%0d: o_ena=%b expected %b", k, ena, exp_ena);
            end
            if (exp_ena) begin
                total++;
                if (inc !== 1'b0) begin
                    bad++; $display("FAIL reset_mid_press_inc k=%0d: o_inc=%b expected 0", k, inc);
                end
            end
        end
        btn_dn = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_run_mode();
        test_set_down();
        test_glitch();
        test_autorepeat();
        test_both_block();
        test_reset_mid_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
